// File: rtl/t2mi_pointer_scheduler_if.sv
// Bus bundle between the T2-MI pointer scheduler, the length FIFO and the TS packer.
// The master modport is the scheduler side; the slave modport is the environment side.
interface t2mi_pointer_scheduler_if #(
    parameter int LEN_W = 16
);
    logic             ENABLE;
    logic [LEN_W-1:0] LEN_IN;
    logic             LEN_VALID;
    logic             LEN_RD;
    logic [3:0]       PACKER_STATE;
    logic [7:0]       POINTER;
    logic             START;
    logic             LATE;
    logic [15:0]      PKT_CNT;
    logic             BUSY;

    modport master (
        input  ENABLE, LEN_IN, LEN_VALID, PACKER_STATE,
        output LEN_RD, POINTER, START, LATE, PKT_CNT, BUSY
    );

    modport slave (
        output ENABLE, LEN_IN, LEN_VALID, PACKER_STATE,
        input  LEN_RD, POINTER, START, LATE, PKT_CNT, BUSY
    );
endinterface

// File: rtl/t2mi_pointer_scheduler.sv
// T2-MI pointer scheduler: tracks T2-MI packet boundaries through a show-ahead
// length FIFO and decides, per TS packet, the POINTER code handed to the packer.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for ENABLE and a first length before starting
// CALC    | one-cycle decision on the remaining byte count
// POP     | consuming lengths until the current TS payload is filled
// COMMIT  | register the decided POINTER
// START   | one-shot START pulse after the very first commit
// WAITPKT | waiting for the packer to enter its payload state
module t2mi_pointer_scheduler #(
    parameter int LEN_W    = 16,
    parameter int PTR_NONE = 255
) (
    input logic                      CLK,
    input logic                      RST,
    t2mi_pointer_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_POP,
        S_COMMIT,
        S_START,
        S_WAITPKT
    } state_t;

    localparam logic [LEN_W-1:0] TS_PAYLOAD = LEN_W'(184);
    localparam logic [LEN_W-1:0] AF_ONE     = LEN_W'(183);
    localparam logic [7:0]       PTR_NONE_C = 8'(PTR_NONE);
    localparam logic [3:0]       PS_HEADER  = 4'd1;
    localparam logic [3:0]       PS_AFPTR   = 4'd2;
    localparam logic [3:0]       PS_PAYLOAD = 4'd3;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] avail;
    logic [7:0]       next_ptr;
    logic [7:0]       pointer;
    logic             late;
    logic [15:0]      pkt_cnt;
    logic             started;
    logic             pop_gap;
    logic [3:0]       ps_prev;
    logic             len_rd;
    logic             start_p;
    logic             busy;
    logic             payload_entry;
    logic [LEN_W-1:0] len_eff;

    // A zero-length word still occupies one byte of the stream.
    assign len_eff       = (bus.LEN_IN == '0) ? LEN_W'(1) : bus.LEN_IN;
    assign payload_entry = (bus.PACKER_STATE == PS_PAYLOAD) &&
                           ((ps_prev == PS_HEADER) || (ps_prev == PS_AFPTR));
    assign busy          = (state == S_CALC) || (state == S_POP);

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic plus the combinational pop and start strobes.
    always_comb begin
        state_nxt = state;
        len_rd    = 1'b0;
        start_p   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.ENABLE && bus.LEN_VALID) state_nxt = S_CALC;
            end
            S_CALC: begin
                if (rem >= AF_ONE) state_nxt = S_COMMIT;
                else               state_nxt = S_POP;
            end
            S_POP: begin
                // pop_gap leaves one cycle for the FIFO head to refresh after a pop
                if (bus.LEN_VALID && !pop_gap) begin
                    len_rd = 1'b1;
                    if (len_eff >= avail) state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_nxt = started ? S_WAITPKT : S_START;
            end
            S_START: begin
                start_p   = 1'b1;
                state_nxt = S_WAITPKT;
            end
            S_WAITPKT: begin
                if (payload_entry) state_nxt = S_CALC;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte accounting, pointer commit, packet counter and late flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rem      <= '0;
            avail    <= '0;
            next_ptr <= '0;
            pointer  <= '0;
            late     <= 1'b0;
            pkt_cnt  <= '0;
            started  <= 1'b0;
            pop_gap  <= 1'b0;
            ps_prev  <= '0;
        end else begin
            ps_prev <= bus.PACKER_STATE;
            pop_gap <= 1'b0;
            if (busy && (bus.PACKER_STATE == PS_HEADER)) late <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (bus.ENABLE && bus.LEN_VALID) rem <= '0;
                end
                S_CALC: begin
                    if (rem >= TS_PAYLOAD) begin
                        next_ptr <= PTR_NONE_C;
                        rem      <= rem - TS_PAYLOAD;
                    end else if (rem == AF_ONE) begin
                        next_ptr <= 8'd183;
                        rem      <= '0;
                    end else begin
                        next_ptr <= rem[7:0];
                        avail    <= AF_ONE - rem;
                    end
                end
                S_POP: begin
                    if (len_rd) begin
                        pkt_cnt <= pkt_cnt + 16'd1;
                        if (len_eff > avail) begin
                            rem <= len_eff - avail;
                        end else if (len_eff == avail) begin
                            rem <= '0;
                        end else begin
                            avail   <= avail - len_eff;
                            pop_gap <= 1'b1;
                        end
                    end
                end
                S_COMMIT: pointer <= next_ptr;
                S_START:  started <= 1'b1;
                default:  ;
            endcase
        end
    end

    assign bus.LEN_RD  = len_rd;
    assign bus.START   = start_p;
    assign bus.POINTER = pointer;
    assign bus.LATE    = late;
    assign bus.PKT_CNT = pkt_cnt;
    assign bus.BUSY    = busy;

endmodule
